// File: rtl/mapper225_multicart_ng.sv
// Mapper 225 family multicart: address-latched NROM game select, lockable outer bank,
// 4-bit scratch RAM at $5800-$5FFF and a reset-vector detector that returns to the menu.
module mapper225_multicart_ng #(
  parameter int OUTER_BITS    = 2,
  parameter int RAM_DEPTH     = 4,
  parameter int RESET_TO_MENU = 1
) (
  input  logic                  m2,
  input  logic                  reset,
  input  logic                  romsel,
  input  logic                  cpu_rw_in,
  input  logic [14:0]           cpu_addr_in,
  input  logic [7:0]            cpu_data_in,
  output logic [7:0]            cpu_data_out,
  output logic                  cpu_data_oe,
  output logic [8+OUTER_BITS:0] cpu_addr_out,
  output logic                  cpu_flash_ce,
  input  logic [3:0]            ppu_addr_in,
  output logic [9+OUTER_BITS:0] ppu_addr_out,
  output logic                  ppu_flash_ce,
  output logic                  ppu_ciram_a10,
  output logic                  ppu_ciram_ce,
  output logic                  locked,
  output logic                  led
);

  localparam int OW = (OUTER_BITS > 0) ? OUTER_BITS : 1;
  localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  typedef enum logic {
    IDLE,
    GOT_LO
  } state_t;

  state_t         state;
  logic [6:0]     chr_bank;
  logic [6:0]     prg_bank;
  logic           prg_mode;
  logic           mirroring;
  logic [OW-1:0]  outer;
  logic           lock;
  logic [3:0]     ram [RAM_DEPTH];

  logic           inner_wr;
  logic           outer_wr;
  logic           ram_wr;
  logic           ram_rd;
  logic           vec_lo;
  logic           vec_hi;
  logic           fire;
  logic [IW-1:0]  ram_idx;
  logic [6:0]     prg_index;
  logic           unused_data;

  assign inner_wr = ~romsel & ~cpu_rw_in;
  assign outer_wr = romsel & ~cpu_rw_in & (cpu_addr_in[14:11] == 4'b1010);
  assign ram_wr   = romsel & ~cpu_rw_in & (cpu_addr_in[14:11] == 4'b1011);
  assign ram_rd   = romsel &  cpu_rw_in & (cpu_addr_in[14:11] == 4'b1011);
  assign vec_lo   = ~romsel & cpu_rw_in & (cpu_addr_in == 15'h7FFC);
  assign vec_hi   = ~romsel & cpu_rw_in & (cpu_addr_in == 15'h7FFD);
  assign ram_idx  = (RAM_DEPTH > 1) ? cpu_addr_in[IW-1:0] : '0;
  // The menu return fires on the edge that samples the $FFFD read following $FFFC.
  assign fire     = (RESET_TO_MENU != 0) && (state == GOT_LO) && vec_hi;

  assign unused_data = ^cpu_data_in[6:4];

  always_ff @(posedge m2) begin
    if (reset) begin
      chr_bank  <= 7'h00;
      prg_bank  <= 7'h00;
      prg_mode  <= 1'b0;
      mirroring <= 1'b0;
      outer     <= '0;
      lock      <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) begin
        ram[i] <= 4'h0;
      end
      state     <= IDLE;
    end else begin
      if (fire) begin
        chr_bank  <= 7'h00;
        prg_bank  <= 7'h00;
        prg_mode  <= 1'b0;
        mirroring <= 1'b0;
        outer     <= '0;
        lock      <= 1'b0;
      end else begin
        if (inner_wr) begin
          chr_bank  <= {cpu_addr_in[14], cpu_addr_in[5:0]};
          prg_bank  <= {cpu_addr_in[14], cpu_addr_in[11:6]};
          prg_mode  <= cpu_addr_in[12];
          mirroring <= cpu_addr_in[13];
        end
        if (outer_wr && !lock) begin
          if (OUTER_BITS > 0) begin
            outer <= cpu_data_in[OW-1:0];
          end
          lock <= cpu_data_in[7];
        end
        if (ram_wr) begin
          ram[ram_idx] <= cpu_data_in[3:0];
        end
      end
      // Repeated $FFFC reads keep the detector armed; any other cycle disarms it.
      case (state)
        IDLE:    state <= (RESET_TO_MENU != 0 && vec_lo) ? GOT_LO : IDLE;
        GOT_LO:  state <= (RESET_TO_MENU != 0 && vec_lo) ? GOT_LO : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign prg_index = prg_mode ? prg_bank : {prg_bank[6:1], cpu_addr_in[14]};

  generate
    if (OUTER_BITS > 0) begin : g_outer
      assign cpu_addr_out = {outer, prg_index, cpu_addr_in[13:12]};
      assign ppu_addr_out = {outer, chr_bank, ppu_addr_in[2:0]};
    end else begin : g_flat
      assign cpu_addr_out = {prg_index, cpu_addr_in[13:12]};
      assign ppu_addr_out = {chr_bank, ppu_addr_in[2:0]};
    end
  endgenerate

  assign cpu_data_oe   = ram_rd;
  assign cpu_data_out  = ram_rd ? {4'h0, ram[ram_idx]} : 8'h00;
  assign cpu_flash_ce  = romsel;
  assign ppu_flash_ce  = ppu_addr_in[3];
  assign ppu_ciram_ce  = ~ppu_addr_in[3];
  assign ppu_ciram_a10 = mirroring ? ppu_addr_in[1] : ppu_addr_in[0];
  assign locked        = lock;
  assign led           = ~romsel;

endmodule
